// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester arbiter.
// Holds the requester count, the index width, the FSM state enum and the one-hot helper.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Searches ptr, ptr+1, ... in round-robin mode, or 3 down to 0 in fixed mode.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic [NREQ-1:0] mask,
  input  logic            rr_en,
  output logic [IDW-1:0]  win_id,
  output logic            win_valid
);

  logic [NREQ-1:0] eff;
  logic [IDW-1:0]  cand;

  always_comb begin
    eff       = req & mask;
    win_id    = '0;
    win_valid = 1'b0;
    cand      = '0;
    // The first eligible candidate in search order wins; later hits are ignored.
    for (int i = 0; i < NREQ; i++) begin
      cand = rr_en ? (ptr + IDW'(i)) : IDW'(NREQ - 1 - i);
      if (!win_valid && eff[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: holds each grant until the owner releases it,
// and force-rotates to a waiting requester once the owner has held it for MAX_HOLD cycles.
module req_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rr_en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            pre_q, pre_d;

  logic [NREQ-1:0] mask;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            owner_req;
  logic            expired;
  logic            take_win;

  assign owner_req = req[id_q];
  assign expired   = (state_q == BUSY) && owner_req && (hold_q >= HOLD_MAX);
  // An expired owner that still requests is kept out of the search so someone else wins.
  assign mask      = expired ? ~idx_to_onehot(id_q) : '1;

  rr_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .mask      (mask),
    .rr_en     (rr_en),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    pre_d    = 1'b0;
    take_win = 1'b0;
    unique case (state_q)
      IDLE: take_win = win_valid;
      BUSY: begin
        if (!owner_req) begin
          if (win_valid) begin
            take_win = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end else if (win_valid) begin
          take_win = 1'b1;
          pre_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_win) begin
      state_d = BUSY;
      gnt_d   = idx_to_onehot(win_id);
      id_d    = win_id;
      hold_d  = 8'd1;
      ptr_d   = win_id + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == BUSY);
  assign preempt   = pre_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed bench for req_arbiter4 with a rule-level reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_req_arbiter4;

  localparam int MAXH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_en = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  bit mValid = 1'b0;
  bit mPre   = 1'b0;
  int mOwner = 0;
  int mHold  = 0;
  int mPtr   = 0;

  req_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  function automatic int pickWinner(input logic [3:0] r, input int p, input bit rr, input int excl);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = rr ? ((p + k) % 4) : (3 - k);
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model: one arbitration decision per rising edge, straight from the rules.
  always @(posedge clk or negedge rst_n) begin : modelStep
    int w;
    if (!rst_n) begin
      mValid = 1'b0; mPre = 1'b0; mOwner = 0; mHold = 0; mPtr = 0;
    end else begin
      mPre = 1'b0;
      w    = -1;
      if (!mValid || !req[mOwner]) begin
        w = pickWinner(req, mPtr, rr_en, -1);
        if (w < 0) begin
          mValid = 1'b0; mOwner = 0; mHold = 0;
        end
      end else if (mHold < MAXH) begin
        mHold = mHold + 1;
      end else begin
        w = pickWinner(req, mPtr, rr_en, mOwner);
        if (w >= 0) mPre = 1'b1;
      end
      if (w >= 0) begin
        mValid = 1'b1; mOwner = w; mHold = 1; mPtr = (w + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin : compareModel
    logic [3:0] eg;
    logic [1:0] ei;
    eg = mValid ? (4'b0001 << mOwner) : 4'b0000;
    ei = mValid ? 2'(mOwner) : 2'b00;
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== {eg, ei, mValid, mPre}) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t actual gnt=%b id=%0d v=%b pre=%b required gnt=%b id=%0d v=%b pre=%b",
               $time, gnt, gnt_id, gnt_valid, preempt, eg, ei, mValid, mPre);
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input bit rr, input int cycles);
    req   = r;
    rr_en = rr;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eGnt, input int eId,
                             input bit eValid, input bit ePre);
    logic [3:0] mg;
    checks++;
    if (gnt !== eGnt || gnt_id !== 2'(eId) || gnt_valid !== eValid || preempt !== ePre) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual gnt=%b id=%0d v=%b pre=%b required gnt=%b id=%0d v=%b pre=%b",
               name, $time, gnt, gnt_id, gnt_valid, preempt, eGnt, eId, eValid, ePre);
    end
    mg = mValid ? (4'b0001 << mOwner) : 4'b0000;
    checks++;
    if (mg !== eGnt || mValid !== eValid || mPre !== ePre) begin
      errors++;
      $display("[TB] FAIL %s_model t=%0t model gnt=%b v=%b pre=%b required gnt=%b v=%b pre=%b",
               name, $time, mg, mValid, mPre, eGnt, eValid, ePre);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_init", 4'b0000, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(4'b0101, 1'b0, 1);
    checkOutput("fixed_first", 4'b0100, 2, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("fixed_handoff", 4'b0001, 0, 1'b1, 1'b0);

    // Reset lands between clock edges while requester 0 owns the resource.
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 4'b0000, 0, 1'b0, 1'b0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b0, 2);
    checkOutput("reset_stable", 4'b0000, 0, 1'b0, 1'b0);

    applyStimulus(4'b1111, 1'b1, 1);
    checkOutput("rr_0", 4'b0001, 0, 1'b1, 1'b0);
    applyStimulus(4'b1110, 1'b1, 1);
    checkOutput("rr_1", 4'b0010, 1, 1'b1, 1'b0);
    applyStimulus(4'b1101, 1'b1, 1);
    checkOutput("rr_2", 4'b0100, 2, 1'b1, 1'b0);
    applyStimulus(4'b1011, 1'b1, 1);
    checkOutput("rr_3", 4'b1000, 3, 1'b1, 1'b0);
    applyStimulus(4'b0111, 1'b1, 1);
    checkOutput("rr_wrap", 4'b0001, 0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("rr_idle", 4'b0000, 0, 1'b0, 1'b0);

    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("hold_start", 4'b0010, 1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 1'b1, 3);
    checkOutput("hold_4th", 4'b0010, 1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 1'b1, 1);
    checkOutput("hold_preempt", 4'b1000, 3, 1'b1, 1'b1);
    applyStimulus(4'b1010, 1'b1, 1);
    checkOutput("hold_pulse_end", 4'b1000, 3, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("hold_idle", 4'b0000, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0100, 1'b1, 1);
      checkOutput("saturate", 4'b0100, 2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1, 1);

    applyStimulus(4'b0001, 1'b1, 1);
    checkOutput("simul_start", 4'b0001, 0, 1'b1, 1'b0);
    applyStimulus(4'b0011, 1'b1, 3);
    checkOutput("simul_held", 4'b0001, 0, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("simul_release", 4'b0010, 1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 2);
    checkOutput("final_idle", 4'b0000, 0, 1'b0, 1'b0);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter4.md
# req_arbiter4

Four-requester arbiter that shares a single downstream resource, such as a bus or an encoder datapath, among four clients. It picks a winner from the request vector with a rotating-priority encoder, holds the grant for the winner until it releases, and force-rotates after a programmable hold limit. It sits between the request sources and the shared resource, and drives the one-hot grant and the encoded winner index (with valid flag) that the resource select logic consumes.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles before forced rotation when others are waiting; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rr_en  input  1  1 = round-robin priority; 0 = fixed priority (req[3] highest, req[0] lowest).
- req  input  4  request vector; requester i holds req[i] high for as long as it wants the resource.
- gnt  output  4  one-hot grant, registered; all-zero when nothing is granted.
- gnt_id  output  2  index of the granted requester, registered; 2'b00 when gnt_valid = 0.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse on the cycle a grant is revoked by the hold limit.

## Operation
- States: IDLE (no grant) and BUSY (grant held by owner).
- Priority pointer ptr[1:0] identifies the highest-priority index.
  - Round-robin: search order is ptr, ptr+1, … mod 4. After each new grant to index k, ptr becomes k+1 mod 4.
  - Fixed: search order is 3, 2, 1, 0, and ptr is ignored but still updated.
- IDLE:
  - If any req bit is set, grant the search winner, go to BUSY, and clear hold_cnt to 1.
  - Otherwise stay in IDLE.
- BUSY, owner still requesting, hold_cnt < MAX_HOLD: keep the grant and increment hold_cnt.
- BUSY, owner still requesting, hold_cnt = MAX_HOLD, another req bit set:
  - Revoke the grant and grant the next winner among the other requesters; the owner is excluded this cycle.
  - Pulse preempt, and reload hold_cnt to 1.
- BUSY, owner still requesting, hold_cnt = MAX_HOLD, no other request: keep the grant; hold_cnt saturates at MAX_HOLD.
- BUSY, owner dropped req:
  - If other requests are present, grant the search winner directly, with no idle bubble, and set hold_cnt to 1.
  - Otherwise go to IDLE.
- Grant is never given to a requester whose req bit is low in the sampled cycle.
- gnt, gnt_id and gnt_valid are always mutually consistent.
- rr_en is sampled only at arbitration points; changing it mid-grant does not affect the current owner.
- hold_cnt is 8 bits wide.

## Timing
- All outputs are registered.
- Reset (asynchronous, active-low):
  - State = IDLE, ptr = 0, hold_cnt = 0.
  - gnt = 4'b0000, gnt_id = 2'b00, gnt_valid = 0, preempt = 0.
  - Outputs take their reset values immediately on assertion, independent of clk.
- Latency: req sampled at edge t produces gnt at edge t+1, i.e. one cycle.
- Release: owner req low at edge t; gnt changes (to a new owner or to zero) at edge t+1.
- Back-to-back handoff is possible with no gap cycles.
- Simultaneous events: owner release in the same cycle as hold expiry is treated as a release, so preempt stays 0.
- Reset mid-grant drops the grant at once. The first post-reset arbitration uses ptr = 0.
- preempt is high for exactly one cycle, aligned with the new gnt value.

## Structure
- Package arb_pkg holds:
  - NREQ = 4 and IDW = 2.
  - The state enum {IDLE, BUSY}.
  - The function idx_to_onehot.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[3:0], ptr[1:0], mask[3:0], rr_en.
  - Outputs: win_id[1:0], win_valid.
  - The mask is used to exclude the preempted owner.
- Top level holds the FSM, ptr, hold_cnt and output registers. Expected size is about 150–250 lines total.

## Test plan
- Reset and idle: assert rst_n = 0 mid-grant, then release it with req = 4'b0000. Required: gnt = 0000, gnt_valid = 0, gnt_id = 00 immediately and stable afterwards.
- Fixed priority: rr_en = 0, req = 4'b0101 at t. Required: gnt = 0100, gnt_id = 2 at t+1. Drop req[2]: gnt = 0001, gnt_id = 0 on the next cycle, with no idle cycle.
- Round-robin fairness: rr_en = 1, req = 4'b1111, each owner releasing after 1 cycle. Required: grant order 0, 1, 2, 3, 0, with ptr wrapping from 3 to 0.
- Hold limit: MAX_HOLD = 4, req[1] held, req[3] raised. Required: gnt = 0010 for 4 cycles, then gnt = 1000 with preempt = 1 for one cycle.
- Saturation: MAX_HOLD = 4, only req[2] held for 10 cycles. Required: gnt stays 0100 and preempt never fires.
- Simultaneous release and expiry: owner drops req on the cycle hold_cnt = MAX_HOLD while another request is waiting. Required: the next winner is granted and preempt = 0.
